// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide data memory.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned requests instead of aligning.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_data_o,
  input  logic [WIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {
    IDLE, RD, CAP, WR
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic [15:0] wdat_q;

  logic        accept, trap;
  logic [1:0]  size_n, off_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [WIDTH-1:0] ld_val, merged;

  assign accept = (state_q == IDLE) && req_i;

  // Illegal size 11 behaves as a word access.
  assign size_n = (size_i == 2'b11) ? 2'b10 : size_i;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal;
  assign misal = (size_i == 2'b11)
               | ((size_i == 2'b01) & addr_i[0])
               | ((size_i == 2'b10) & |addr_i[1:0]);
  assign trap  = misal;
  assign off_n = addr_i[1:0];
`else
  assign trap = 1'b0;
  // Misaligned offsets are rounded down to the access size.
  always_comb begin
    off_n = 2'b00;
    unique case (size_n)
      2'b00:   off_n = addr_i[1:0];
      2'b01:   off_n = {addr_i[1], 1'b0};
      default: off_n = 2'b00;
    endcase
  end
`endif

  assign lane_b = mem_data_i[{off_q, 3'b000} +: 8];
  assign lane_h = mem_data_i[{off_q[1], 4'h0} +: 16];

  // Load lane extraction with sign or zero extension.
  always_comb begin
    ld_val = mem_data_i;
    unique case (size_q)
      2'b00: ld_val = {{(WIDTH-8){~uns_q & lane_b[7]}}, lane_b};
      2'b01: ld_val = {{(WIDTH-16){~uns_q & lane_h[15]}}, lane_h};
      default: ld_val = mem_data_i;
    endcase
  end

  // Sub-word store merge into the word just read.
  always_comb begin
    merged = mem_data_i;
    unique case (size_q)
      2'b00: merged[{off_q, 3'b000} +: 8] = wdat_q[7:0];
      2'b01: merged[{off_q[1], 4'h0} +: 16] = wdat_q;
      default: merged = mem_data_i;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_i && !trap) begin
          if (we_i && size_n == 2'b10) state_d = WR;
          else                         state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: state_d = we_q ? WR : IDLE;
      WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q != IDLE);
  assign mem_cs_o = (state_q != IDLE);
  assign mem_we_o = (state_q == WR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, load result, write data and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      wdat_q     <= '0;
      done_o     <= 1'b0;
      data_o     <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        we_q       <= we_i;
        uns_q      <= unsigned_i;
        size_q     <= size_n;
        off_q      <= off_n;
        wdat_q     <= data_i[15:0];
        mem_addr_o <= {addr_i[WIDTH-1:2], 2'b00};
        if (trap) done_o <= 1'b1;
        else if (we_i && size_n == 2'b10) mem_data_o <= data_i;
      end
      if (state_q == CAP) begin
        if (we_q) mem_data_o <= merged;
        else begin
          data_o <= ld_val;
          done_o <= 1'b1;
        end
      end
      if (state_q == WR) done_o <= 1'b1;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment pulse alongside the trap completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_o <= 1'b0;
    else        err_o <= accept & trap;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
